// File: rtl/pixel_addr_gen.sv
// pixel_addr_gen -- display-side source address generator.
// Walks the display raster, applies mirror / offset (and optional 2x zoom)
// to each display pixel, and presents {valid, 19-bit SRAM word address}
// to the SRAM controller read port through a ready/read handshake.
// Optional feature macro: PIXEL_ADDR_GEN_ZOOM_EN (2x zoom selected by iSW[2]).
// Three-stage pipeline: stage 0 mirror/zoom, stage 1 offset and range check,
// stage 2 linear address (the output register).

module pixel_addr_gen #(
    parameter int DISPLAY_WIDTH  = 800,
    parameter int DISPLAY_HEIGHT = 480,
    parameter int INPUT_WIDTH    = 800,
    parameter int INPUT_HEIGHT   = 480
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        iREAD,
    input  logic [17:0] iSW,
    output logic [19:0] oADDRESS,
    output logic        oREADY_N,
    output logic        oFRAME_START
);

    localparam int DXW = (DISPLAY_WIDTH  > 1) ? $clog2(DISPLAY_WIDTH)  : 1;
    localparam int DYW = (DISPLAY_HEIGHT > 1) ? $clog2(DISPLAY_HEIGHT) : 1;
    localparam int SXW = 11;
    localparam int SYW = 10;
    localparam int AW  = 19;

    // raster counters and per-frame transform snapshot
    logic [DXW-1:0] dx_q, dx_d;
    logic [DYW-1:0] dy_q, dy_d;
    logic           snap_hm_q;
    logic           snap_vm_q;
    logic [8:0]     snap_xoff_q;
    logic [5:0]     snap_yoff_q;

    // transform actually applied to the pixel being issued
    logic           frame_origin;
    logic           hm_sel;
    logic           vm_sel;
    logic [8:0]     xoff_sel;
    logic [5:0]     yoff_sel;

`ifdef PIXEL_ADDR_GEN_ZOOM_EN
    logic           snap_zoom_q;
    logic           zoom_sel;
`else
    logic           unused_zoom_sw;
    assign unused_zoom_sw = iSW[2];
`endif

    // stage 0: mirrored (and optionally zoomed) display coordinates
    logic           s0_v_q;
    logic           s0_fs_q;
    logic [DXW-1:0] s0_mx_q, s0_mx_d;
    logic [DYW-1:0] s0_my_q, s0_my_d;
    logic [8:0]     s0_xoff_q;
    logic [5:0]     s0_yoff_q;

    // stage 1: source coordinates and in-frame flag
    logic           s1_v_q;
    logic           s1_fs_q;
    logic [SXW-1:0] s1_sx_q, s1_sx_d;
    logic [SYW-1:0] s1_sy_q, s1_sy_d;
    logic           s1_inr_q, s1_inr_d;

    // stage 2: presented entry
    logic           s2_v_q;
    logic           s2_fs_q;
    logic [19:0]    s2_addr_q, s2_addr_d;
    logic [AW-1:0]  lin_addr;

    logic           advance;

    // The whole pipeline moves together; a full output register blocks it
    // until the consumer pops.
    assign advance = ~s2_v_q | iREAD;

    // Raster stepping and transform selection for the pixel about to issue.
    // At the frame origin the live switches are used directly so the origin
    // pixel and the rest of its frame see the same settings.
    always_comb begin
        frame_origin = (dx_q == '0) && (dy_q == '0);
        dx_d = dx_q;
        dy_d = dy_q;
        if (dx_q == DXW'(DISPLAY_WIDTH - 1)) begin
            dx_d = '0;
            if (dy_q == DYW'(DISPLAY_HEIGHT - 1)) begin
                dy_d = '0;
            end else begin
                dy_d = dy_q + DYW'(1);
            end
        end else begin
            dx_d = dx_q + DXW'(1);
        end

        hm_sel   = frame_origin ? iSW[0]     : snap_hm_q;
        vm_sel   = frame_origin ? iSW[1]     : snap_vm_q;
        xoff_sel = frame_origin ? iSW[11:3]  : snap_xoff_q;
        yoff_sel = frame_origin ? iSW[17:12] : snap_yoff_q;
`ifdef PIXEL_ADDR_GEN_ZOOM_EN
        zoom_sel = frame_origin ? iSW[2]     : snap_zoom_q;
`endif
    end

    // Stage 0 combinational: mirror, then optional zoom halving.
    always_comb begin
        s0_mx_d = hm_sel ? (DXW'(DISPLAY_WIDTH - 1) - dx_q) : dx_q;
        s0_my_d = vm_sel ? (DYW'(DISPLAY_HEIGHT - 1) - dy_q) : dy_q;
`ifdef PIXEL_ADDR_GEN_ZOOM_EN
        if (zoom_sel) begin
            s0_mx_d = s0_mx_d >> 1;
            s0_my_d = s0_my_d >> 1;
        end
`endif
    end

    // Stage 1 combinational: add offsets, check against the stored frame.
    always_comb begin
        s1_sx_d  = SXW'(s0_mx_q) + SXW'(s0_xoff_q);
        s1_sy_d  = SYW'(s0_my_q) + SYW'({s0_yoff_q, 3'b000});
        s1_inr_d = (s1_sx_d < SXW'(INPUT_WIDTH)) && (s1_sy_d < SYW'(INPUT_HEIGHT));
    end

    // Stage 2 combinational: linear address, forced to all-ones when outside.
    always_comb begin
        lin_addr  = AW'(s1_sy_q) * AW'(INPUT_WIDTH) + AW'(s1_sx_q);
        s2_addr_d = s1_inr_q ? {1'b1, lin_addr} : {1'b0, {AW{1'b1}}};
    end

    // Raster counters and frame snapshot advance with the pipeline.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            dx_q        <= '0;
            dy_q        <= '0;
            snap_hm_q   <= 1'b0;
            snap_vm_q   <= 1'b0;
            snap_xoff_q <= '0;
            snap_yoff_q <= '0;
`ifdef PIXEL_ADDR_GEN_ZOOM_EN
            snap_zoom_q <= 1'b0;
`endif
        end else if (advance) begin
            dx_q <= dx_d;
            dy_q <= dy_d;
            if (frame_origin) begin
                snap_hm_q   <= iSW[0];
                snap_vm_q   <= iSW[1];
                snap_xoff_q <= iSW[11:3];
                snap_yoff_q <= iSW[17:12];
`ifdef PIXEL_ADDR_GEN_ZOOM_EN
                snap_zoom_q <= iSW[2];
`endif
            end
        end
    end

    // Stage 0 register: mirrored coordinates plus the offsets for this entry.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            s0_v_q    <= 1'b0;
            s0_fs_q   <= 1'b0;
            s0_mx_q   <= '0;
            s0_my_q   <= '0;
            s0_xoff_q <= '0;
            s0_yoff_q <= '0;
        end else if (advance) begin
            s0_v_q    <= 1'b1;
            s0_fs_q   <= frame_origin;
            s0_mx_q   <= s0_mx_d;
            s0_my_q   <= s0_my_d;
            s0_xoff_q <= xoff_sel;
            s0_yoff_q <= yoff_sel;
        end
    end

    // Stage 1 register: source coordinates and range flag.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1_v_q   <= 1'b0;
            s1_fs_q  <= 1'b0;
            s1_sx_q  <= '0;
            s1_sy_q  <= '0;
            s1_inr_q <= 1'b0;
        end else if (advance) begin
            s1_v_q   <= s0_v_q;
            s1_fs_q  <= s0_fs_q;
            s1_sx_q  <= s1_sx_d;
            s1_sy_q  <= s1_sy_d;
            s1_inr_q <= s1_inr_d;
        end
    end

    // Stage 2 register: the entry presented to the SRAM controller.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            s2_v_q    <= 1'b0;
            s2_fs_q   <= 1'b0;
            s2_addr_q <= '0;
        end else if (advance) begin
            s2_v_q    <= s1_v_q;
            s2_fs_q   <= s1_fs_q;
            s2_addr_q <= s2_addr_d;
        end
    end

    assign oADDRESS     = s2_addr_q;
    assign oFRAME_START = s2_fs_q;
    assign oREADY_N     = ~s2_v_q;

endmodule

// File: tb/tb_pixel_addr_gen.sv
// Testbench for pixel_addr_gen: a short-frame instance (800 x 12) for
// wrap / random checks and a full-size instance for the 480-line cases.

module tb_pixel_addr_gen;

    localparam int W   = 800;
    localparam int H   = 12;
    localparam int NPX = W * H;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;

    logic        rd = 1'b0;
    logic [17:0] sw = '0;
    logic [19:0] addr;
    logic        rdy_n;
    logic        fs;

    logic        rd_f = 1'b0;
    logic [17:0] sw_f = '0;
    logic [19:0] addr_f;
    logic        rdy_n_f;
    logic        fs_f;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    pixel_addr_gen #(
        .DISPLAY_WIDTH (W),
        .DISPLAY_HEIGHT(H),
        .INPUT_WIDTH   (W),
        .INPUT_HEIGHT  (H)
    ) u_small (
        .CLK         (CLK),
        .RESET       (RESET),
        .iREAD       (rd),
        .iSW         (sw),
        .oADDRESS    (addr),
        .oREADY_N    (rdy_n),
        .oFRAME_START(fs)
    );

    pixel_addr_gen u_full (
        .CLK         (CLK),
        .RESET       (RESET),
        .iREAD       (rd_f),
        .iSW         (sw_f),
        .oADDRESS    (addr_f),
        .oREADY_N    (rdy_n_f),
        .oFRAME_START(fs_f)
    );

    typedef struct {
        logic [17:0] sw;
        int          idx;
        logic [19:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: display pixel index -> expected {valid, address}.
    function automatic logic [19:0] ref_addr(input int p, input logic [17:0] s,
                                             input int dw, input int dh,
                                             input int iw, input int ih);
        int dx, dy, mx, my, sx, sy;
        dx = p % dw;
        dy = p / dw;
        mx = s[0] ? (dw - 1 - dx) : dx;
        my = s[1] ? (dh - 1 - dy) : dy;
`ifdef PIXEL_ADDR_GEN_ZOOM_EN
        if (s[2]) begin
            mx = mx / 2;
            my = my / 2;
        end
`endif
        sx = mx + int'(s[11:3]);
        sy = my + 8 * int'(s[17:12]);
        if (sx < iw && sy < ih) return {1'b1, 19'(sy * iw + sx)};
        return 20'h7FFFF;
    endfunction

    function automatic logic [17:0] rand_sw();
        logic [5:0] yo;
        logic [8:0] xo;
        logic [2:0] b;
        yo = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 1));
        xo = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 20));
        b  = 3'($urandom_range(0, 7));
        return {yo, xo, b};
    endfunction

    task automatic do_reset(input logic [17:0] s, input logic [17:0] s_f);
        RESET = 1'b1;
        sw    = s;
        sw_f  = s_f;
        rd    = 1'b1;
        step();
        check("rst_addr", addr, 20'h0);
        check("rst_rdyn", rdy_n, 1'b1);
        check("rst_fs", fs, 1'b0);
        check("rst_rdyn_full", rdy_n_f, 1'b1);
        step();
        RESET = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (rdy_n !== 1'b0 && n < 8) begin
            step();
            n++;
        end
        check("fill_latency", n, 3);
    endtask

    initial begin
        int p;
        logic [17:0] fsw;

        // specific raster points, 800-wide frame with 12 lines
        vecs.push_back('{18'h00000,    0, 20'h80000});
        vecs.push_back('{18'h00000,  805, 20'h80325});
        vecs.push_back('{18'h00001,    0, 20'h8031F});
        vecs.push_back('{18'h00001,  799, 20'h80000});
        vecs.push_back('{18'h00001,  800, 20'h8063F});
        vecs.push_back('{18'h00320,  700, 20'h7FFFF});
        vecs.push_back('{18'h00320,  699, 20'h8031F});
        vecs.push_back('{18'h00002,    0, 20'h82260});
        vecs.push_back('{18'h01000,    0, 20'h81900});
        vecs.push_back('{18'h01000, 3200, 20'h7FFFF});
        vecs.push_back('{18'h00000, 9599, 20'h8257F});
        vecs.push_back('{18'h00003,    0, 20'h8257F});
`ifdef PIXEL_ADDR_GEN_ZOOM_EN
        vecs.push_back('{18'h00004,    1, 20'h80000});
        vecs.push_back('{18'h00004,    3, 20'h80001});
        vecs.push_back('{18'h00004, 1600, 20'h80320});
`else
        vecs.push_back('{18'h00004,    3, 20'h80003});
`endif

        // hand sequence: fill with iREAD low, stall at first entry, full-size v-mirror
        do_reset(18'h0, 18'h00002);
        rd = 1'b0;
        step();
        check("fill_e1", rdy_n, 1'b1);
        step();
        check("fill_e2", rdy_n, 1'b1);
        step();
        check("fill_e3", rdy_n, 1'b0);
        check("first_addr", addr, 20'h80000);
        check("first_fs", fs, 1'b1);
        check("full_vm_first", addr_f, 20'hDD8E0);
        check("full_vm_fs", fs_f, 1'b1);
        rd_f = 1'b1;
        repeat (5) begin
            step();
            rd_f = 1'b0;
            check("idle_hold", addr, 20'h80000);
        end
        check("full_vm_second", addr_f, 20'hDD8E1);
        rd = 1'b1;
        step();
        check("after_idle", addr, 20'h80001);
        check("after_idle_fs", fs, 1'b0);

        // table-driven raster points
        foreach (vecs[i]) begin
            do_reset(vecs[i].sw, 18'h0);
            wait_ready();
            for (int k = 0; k < vecs[i].idx; k++) step();
            check($sformatf("vec%0d_addr", i), addr, vecs[i].exp);
            check($sformatf("vec%0d_fs", i), fs, (vecs[i].idx == 0) ? 1'b1 : 1'b0);
        end

        // stall at 805 for 10 cycles, then release
        do_reset(18'h0, 18'h0);
        wait_ready();
        repeat (805) step();
        rd = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            check("stall_addr", addr, 20'h80325);
            check("stall_rdyn", rdy_n, 1'b0);
        end
        rd = 1'b1;
        step();
        check("stall_release", addr, 20'h80326);

        // reset in mid-frame discards everything in flight
        repeat (4) step();
        RESET = 1'b1;
        step();
        check("midrst_addr", addr, 20'h0);
        check("midrst_rdyn", rdy_n, 1'b1);
        check("midrst_fs", fs, 1'b0);
        RESET = 1'b0;
        wait_ready();
        check("midrst_restart", addr, 20'h80000);

        // mid-frame v-mirror change applies from the next frame only
        do_reset(18'h0, 18'h0);
        wait_ready();
        for (int k = 0; k < NPX; k++) begin
            if (k == 2 * W) sw = 18'h00002;
            if (addr !== {1'b1, 19'(k)}) check("frame_seq", addr, {1'b1, 19'(k)});
            else checks++;
            step();
        end
        check("wrap_addr", addr, 20'h82260);
        check("wrap_fs", fs, 1'b1);
        step();
        check("wrap_next", addr, 20'h82261);

        // randomized read pattern and switch changes against the reference
        fsw = rand_sw();
        do_reset(fsw, 18'h0);
        wait_ready();
        p = 0;
        for (int c = 0; c < 25000; c++) begin
            if (rdy_n !== 1'b0) begin
                check("rnd_ready", rdy_n, 1'b0);
            end else begin
                checks++;
                if (addr !== ref_addr(p, fsw, W, H, W, H)) begin
                    errors++;
                    $display("FAIL rnd_addr p=%0d sw=%h: got %h expected %h",
                             p, fsw, addr, ref_addr(p, fsw, W, H, W, H));
                end
                checks++;
                if (fs !== (p == 0)) begin
                    errors++;
                    $display("FAIL rnd_fs p=%0d: got %b expected %b", p, fs, (p == 0));
                end
            end
            rd = ($urandom_range(0, 3) != 0);
            if (p >= 16 && p <= NPX - 16 && $urandom_range(0, 499) == 0) sw = rand_sw();
            step();
            if (rd) begin
                p++;
                if (p == NPX) begin
                    p = 0;
                    fsw = sw;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
